// File: rtl/grostl_pkg.sv
// Shared Grostl definitions: column type and the controller state encoding
// used by both the forward and inverse SubBytes stages.
package grostl_pkg;

  localparam int unsigned GROSTL_COL_BYTES = 8;

  typedef logic [0:GROSTL_COL_BYTES-1][7:0] grostl_col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } grostl_state_e;

endpackage

// File: rtl/grostl_inv_sbox_lut.sv
// Combinational inverse AES S-box, one byte in, one byte out.
module grostl_inv_sbox_lut (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_o = InvSbox[byte_i];

endmodule

// File: rtl/grostl_inv_sub_bytes_serial.sv
// Serialized inverse SubBytes over one 8-byte column: BYTES_PER_CYCLE shared
// inverse S-boxes walk the column group by group, cnt selecting the group.
module grostl_inv_sub_bytes_serial
  import grostl_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [0:GROSTL_COL_BYTES-1][7:0]      din,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [0:GROSTL_COL_BYTES-1][7:0]      dout,
  output logic                                  busy
);

  localparam int unsigned NumGroups = GROSTL_COL_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NumGroups - 1);

  grostl_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  grostl_col_t     in_reg_q, in_reg_d;
  grostl_col_t     out_reg_q, out_reg_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [2:0] grp_base;
  logic [7:0] lut_in  [BYTES_PER_CYCLE];
  logic [7:0] lut_out [BYTES_PER_CYCLE];

  // Reset masks in_ready so no handshake can complete while rst is high.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));

  assign grp_base = 3'(int'(cnt_q) * int'(BYTES_PER_CYCLE));

  always_comb begin
    for (int k = 0; k < int'(BYTES_PER_CYCLE); k++) begin
      lut_in[k] = in_reg_q[grp_base + 3'(k)];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
    grostl_inv_sbox_lut u_lut (
      .byte_i (lut_in[g]),
      .byte_o (lut_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_reg_d  = in_reg_q;
    out_reg_d = out_reg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_reg_d = din;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < int'(BYTES_PER_CYCLE); k++) begin
          out_reg_d[grp_base + 3'(k)] = lut_out[k];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            in_reg_d = din;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_reg_q    <= '0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_reg_q    <= in_reg_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dout      = out_reg_q;

endmodule

// File: doc/grostl_inv_sub_bytes_serial.md
# grostl_inv_sub_bytes_serial

Serialized inverse SubBytes unit for the 64-bit Grøstl datapath.
- Accepts one 8-byte column over a valid/ready handshake and applies the inverse AES S-box to every byte.
- Uses a configurable number of shared inverse S-box instances, so one column takes several cycles.
- Returns the result over a second valid/ready handshake.
- Sits downstream of the forward SubBytes stage. It is used to undo substitutions in attack/verification flows and as a time-multiplexed, low-area leakage target.

## Interface
Parameters:
- BYTES_PER_CYCLE, 1, bytes substituted per BUSY cycle. Legal values: 1, 2, 4, 8. It equals the number of inverse S-box instances.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  din holds a valid column
- in_ready  output  1  unit can accept a column this cycle
- din  input  [0:7][7:0]  input column, byte 0 first
- out_valid  output  1  dout holds a completed column
- out_ready  input  1  consumer accepts dout this cycle
- dout  output  [0:7][7:0]  substituted column, registered
- busy  output  1  high while in BUSY state

## Operation
- State machine with three states.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture din into in_reg, clear cnt, go to BUSY.
  - BUSY: each cycle write bytes cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 of out_reg as InvS(in_reg byte), then cnt++. On the last group (cnt==8/BYTES_PER_CYCLE-1), go to DONE.
  - DONE: out_valid=1. dout and out_valid are held stable until out_ready. When out_ready=1: if in_valid=1, capture the new din and go to BUSY; otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready to in_ready.
- in_ready=0 whenever rst=1. Handshakes in a cycle where rst=1 are ignored.
- In BUSY, in_valid is ignored. din need only be stable in the accepting cycle.
- cnt width is clog2(8/BYTES_PER_CYCLE), minimum 1 bit. cnt wraps to 0 when the unit enters BUSY.
- Bytes of out_reg not yet written in BUSY keep their previous values. dout is only meaningful while out_valid=1.
- Reset, including reset mid-BUSY or mid-DONE, applies the following on the next edge:
  - state=IDLE, cnt=0, in_reg=0, out_reg=0
  - out_valid=0, busy=0, dout=0
  - any in-flight column is discarded.

## Timing
- Let the input handshake occur at edge E0 and let N=8/BYTES_PER_CYCLE.
  - busy is high after E0 through edge E(N-1).
  - out_valid rises after edge EN, i.e. latency N cycles from acceptance to out_valid.
- BYTES_PER_CYCLE=1: latency 8. BYTES_PER_CYCLE=8: latency 1.
- With out_ready tied high and in_valid continuously high, one column is accepted every N+1 cycles, because DONE lasts one cycle and accepts back-to-back.
- Backpressure: out_valid remains high with dout unchanged for as many cycles as out_ready stays low.

## Structure
- Shared package grostl_pkg holds:
  - GROSTL_COL_BYTES=8
  - typedef grostl_col_t = logic [0:7][7:0]
  - the state enum (IDLE, BUSY, DONE), shared with the forward-path controllers.
- Sub-module grostl_inv_sbox_lut: 8-bit in, 8-bit out, 256-entry combinational inverse AES S-box. Instantiated BYTES_PER_CYCLE times inside a generate loop.
- Byte-group selection into the LUTs is a mux indexed by cnt. Output writes are enabled by cnt decode.

## Test plan
- Test 1: BYTES_PER_CYCLE=1, din=63 7c 77 7b f2 6b 6f c5. Required: dout=00 01 02 03 04 05 06 07, with out_valid rising exactly 8 cycles after acceptance.
- Test 2: din=00 00 00 00 00 00 00 00. Required: dout=52 52 52 52 52 52 52 52. Then din=16 16 16 16 01 01 01 01. Required: dout=ff ff ff ff 09 09 09 09.
- Test 3: round trip over 1000 random columns, each passed through the forward Grøstl SubBytes stage and then this unit. Required: output equals the original column, for every BYTES_PER_CYCLE in {1,2,4,8}. Required latency is 8, 4, 2 and 1 respectively.
- Test 4: backpressure. Hold out_ready=0 for 5 cycles in DONE. Required: out_valid=1 and dout unchanged throughout, and in_ready=0. On the out_ready pulse with in_valid=1, the next column is accepted in that same cycle.
- Test 5: assert rst for 1 cycle during BUSY (cnt=3, BYTES_PER_CYCLE=1). Required on the next cycle: out_valid=0, busy=0, dout=0, in_ready=1. The aborted column is never emitted.
- Test 6: in_valid pulsed during BUSY. Required: the pulse is ignored and in_ready stays 0. Only the first column is produced.
